// File: rtl/fifo_pkg.sv
// Shared constants for the asynchronous FIFO read-side controller.
package fifo_pkg;

   // One extra pointer bit distinguishes full from empty across wrap.
   localparam int PTR_WRAP_BITS = 1;
   localparam int BUF_DEPTH     = 2;

   typedef logic [1:0] buf_cnt_t;

endpackage

// File: rtl/fifo_rd_ctrl_gray2bin.sv
// Combinational Gray-to-binary conversion of a pointer.
module gray2bin #(
   parameter int W = 5
) (
   input  logic [W-1:0] gray_i,
   output logic [W-1:0] bin_o
);

   always_comb begin
      bin_o = '0;
      for (int i = 0; i < W; i++) begin
         bin_o[i] = ^(gray_i >> i);
      end
   end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of an async FIFO: pointer/flag logic plus a
// 2-entry output buffer that hides the one-cycle RAM read latency.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int AE_THRESH  = 2
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic [ADDRSIZE:0]     rq2_wptr,
   output logic [ADDRSIZE:0]     rptr,
   output logic [ADDRSIZE-1:0]   raddr,
   output logic                  rden,
   input  logic [DATA_WIDTH-1:0] rdata_mem,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  rempty,
   output logic                  ralmost_empty,
   output logic [ADDRSIZE:0]     rcount
);

   localparam int PTR_W = ADDRSIZE + PTR_WRAP_BITS;
   localparam logic [PTR_W-1:0] AE_T = PTR_W'(AE_THRESH);

   logic [PTR_W-1:0]      rbin_q, rbin_d;
   logic [PTR_W-1:0]      rptr_q, rptr_d;
   logic [PTR_W-1:0]      rcount_q, rcount_d;
   logic [PTR_W-1:0]      wbin;
   logic                  rempty_q, rempty_d;
   logic                  rae_q, rae_d;
   logic                  inflight_q;
   logic                  vld_q, vld_d;
   buf_cnt_t              cnt_q, cnt_d, wr_idx;
   logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] buf_d [BUF_DEPTH];
   logic                  pop;
   logic [2:0]            occ_after;

   function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   gray2bin #(.W(PTR_W)) u_wptr_conv (
      .gray_i (rq2_wptr),
      .bin_o  (wbin)
   );

   assign pop = vld_q & m_tready;

   // Words held or already requested after this cycle's pop; read only if
   // the buffer is guaranteed a free slot when the RAM word lands.
   assign occ_after = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign rden      = rrst_n & ~rempty_q & (occ_after < 3'(BUF_DEPTH));

   assign raddr         = rbin_q[ADDRSIZE-1:0];
   assign rptr          = rptr_q;
   assign rempty        = rempty_q;
   assign rcount        = rcount_q;
   assign ralmost_empty = rae_q;
   assign m_tvalid      = vld_q;
   assign m_tdata       = buf_q[0];

   always_comb begin
      rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, rden};
      rptr_d   = bin2gray(rbin_d);
      rempty_d = (rptr_d == rq2_wptr);
      rcount_d = wbin - rbin_d;
      rae_d    = (rcount_d <= AE_T);
   end

   // Buffer slot 0 is always the oldest word; a new word lands behind the
   // survivors of this cycle's pop.
   always_comb begin
      buf_d = buf_q;
      if (pop) begin
         buf_d[0] = buf_q[1];
      end
      wr_idx = cnt_q - buf_cnt_t'(pop);
      if (inflight_q) begin
         if (wr_idx == 2'd0) begin
            buf_d[0] = rdata_mem;
         end else begin
            buf_d[1] = rdata_mem;
         end
      end
      cnt_d = cnt_q + buf_cnt_t'(inflight_q) - buf_cnt_t'(pop);
      vld_d = (cnt_d != 2'd0);
   end

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         rbin_q     <= '0;
         rptr_q     <= '0;
         rempty_q   <= 1'b1;
         rae_q      <= 1'b1;
         rcount_q   <= '0;
         inflight_q <= 1'b0;
         cnt_q      <= '0;
         vld_q      <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         rbin_q     <= rbin_d;
         rptr_q     <= rptr_d;
         rempty_q   <= rempty_d;
         rae_q      <= rae_d;
         rcount_q   <= rcount_d;
         inflight_q <= rden;
         cnt_q      <= cnt_d;
         vld_q      <= vld_d;
         buf_q      <= buf_d;
      end
   end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural RAM and write-side model.
module tb_fifo_rd_ctrl;

   logic        rclk;
   logic        rrst_n;
   logic [4:0]  rq2_wptr;
   logic [4:0]  rptr;
   logic [3:0]  raddr;
   logic        rden;
   logic [31:0] rdata_mem;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        rempty;
   logic        ralmost_empty;
   logic [4:0]  rcount;

   logic [31:0] mem [16];
   int          n_cmp;
   int          n_err;

   fifo_rd_ctrl #(.ADDRSIZE(4), .DATA_WIDTH(32), .AE_THRESH(2)) dut (
      .rclk          (rclk),
      .rrst_n        (rrst_n),
      .rq2_wptr      (rq2_wptr),
      .rptr          (rptr),
      .raddr         (raddr),
      .rden          (rden),
      .rdata_mem     (rdata_mem),
      .m_tdata       (m_tdata),
      .m_tvalid      (m_tvalid),
      .m_tready      (m_tready),
      .rempty        (rempty),
      .ralmost_empty (ralmost_empty),
      .rcount        (rcount)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   initial rdata_mem = '0;
   always @(posedge rclk) begin
      if (rden) rdata_mem <= mem[raddr];
   end

   function automatic logic [4:0] g(input int b);
      logic [4:0] x;
      x = b[4:0];
      return x ^ (x >> 1);
   endfunction

   task automatic step();
      @(posedge rclk);
      @(negedge rclk);
   endtask

   task automatic do_reset();
      rrst_n = 1'b0; rq2_wptr = '0; m_tready = 1'b0;
      step(); step();
      rrst_n = 1'b1;
   endtask

   task automatic test_reset();
      rrst_n = 1'b0; rq2_wptr = '0; m_tready = 1'b0;
      step(); step();
      n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL reset_rempty got=%0b exp=1", rempty); end
      n_cmp++; if (rptr !== 5'd0) begin n_err++; $display("FAIL reset_rptr got=%0h exp=0", rptr); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%0b exp=0", m_tvalid); end
      n_cmp++; if (rcount !== 5'd0) begin n_err++; $display("FAIL reset_rcount got=%0d exp=0", rcount); end
      n_cmp++; if (rden !== 1'b0) begin n_err++; $display("FAIL reset_rden got=%0b exp=0", rden); end
      n_cmp++; if (ralmost_empty !== 1'b1) begin n_err++; $display("FAIL reset_ae got=%0b exp=1", ralmost_empty); end
      n_cmp++; if (m_tdata !== 32'd0) begin n_err++; $display("FAIL reset_tdata got=%0h exp=0", m_tdata); end
      rrst_n = 1'b1;
      step();
      n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL idle_rempty got=%0b exp=1", rempty); end
   endtask

   task automatic test_first_word();
      mem[0] = 32'hA5A5_0001;
      rq2_wptr = g(1);
      step();
      n_cmp++; if (rempty !== 1'b0) begin n_err++; $display("FAIL fw_e1_rempty got=%0b exp=0", rempty); end
      n_cmp++; if (rden !== 1'b1) begin n_err++; $display("FAIL fw_e1_rden got=%0b exp=1", rden); end
      n_cmp++; if (rcount !== 5'd1) begin n_err++; $display("FAIL fw_e1_rcount got=%0d exp=1", rcount); end
      n_cmp++; if (ralmost_empty !== 1'b1) begin n_err++; $display("FAIL fw_e1_ae got=%0b exp=1", ralmost_empty); end
      step();
      n_cmp++; if (rden !== 1'b0) begin n_err++; $display("FAIL fw_e2_rden got=%0b exp=0", rden); end
      n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL fw_e2_rempty got=%0b exp=1", rempty); end
      n_cmp++; if (rcount !== 5'd0) begin n_err++; $display("FAIL fw_e2_rcount got=%0d exp=0", rcount); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL fw_e2_tvalid got=%0b exp=0", m_tvalid); end
      n_cmp++; if (rptr !== g(1)) begin n_err++; $display("FAIL fw_e2_rptr got=%0h exp=%0h", rptr, g(1)); end
      step();
      n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL fw_e3_tvalid got=%0b exp=1", m_tvalid); end
      n_cmp++; if (m_tdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL fw_e3_tdata got=%0h exp=a5a50001", m_tdata); end
      m_tready = 1'b1;
      step();
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL fw_pop_tvalid got=%0b exp=0", m_tvalid); end
      n_cmp++; if (rden !== 1'b0) begin n_err++; $display("FAIL fw_pop_rden got=%0b exp=0", rden); end
   endtask

   task automatic test_streaming();
      int beats = 0;
      int gaps = 0;
      int bad = 0;
      do_reset();
      for (int i = 0; i < 8; i++) mem[i] = 32'(i);
      rq2_wptr = g(8);
      m_tready = 1'b1;
      for (int c = 0; c < 40 && beats < 8; c++) begin
         if (m_tvalid) begin
            if (m_tdata !== 32'(beats)) begin
               bad++;
               $display("FAIL stream_data beat=%0d got=%0h exp=%0h", beats, m_tdata, beats);
            end
            beats++;
         end else if (beats > 0) begin
            gaps++;
         end
         step();
      end
      n_cmp++; if (beats !== 8) begin n_err++; $display("FAIL stream_beats got=%0d exp=8", beats); end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stream_order bad=%0d exp=0", bad); end
      n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
      n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL stream_rempty got=%0b exp=1", rempty); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL stream_tvalid got=%0b exp=0", m_tvalid); end
   endtask

   task automatic test_almost_empty();
      do_reset();
      for (int i = 0; i < 3; i++) mem[i] = 32'(50 + i);
      rq2_wptr = g(3);
      step();
      n_cmp++; if (rcount !== 5'd3) begin n_err++; $display("FAIL ae_rcount3 got=%0d exp=3", rcount); end
      n_cmp++; if (ralmost_empty !== 1'b0) begin n_err++; $display("FAIL ae_above got=%0b exp=0", ralmost_empty); end
      step();
      n_cmp++; if (rcount !== 5'd2) begin n_err++; $display("FAIL ae_rcount2 got=%0d exp=2", rcount); end
      n_cmp++; if (ralmost_empty !== 1'b1) begin n_err++; $display("FAIL ae_at got=%0b exp=1", ralmost_empty); end
   endtask

   task automatic test_backpressure();
      int nrd = 0;
      int unsteady = 0;
      int beats = 0;
      int bad = 0;
      do_reset();
      for (int i = 0; i < 16; i++) mem[i] = 32'(100 + i);
      rq2_wptr = g(16);
      m_tready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (rden) nrd++;
         if (m_tvalid && m_tdata !== 32'd100) unsteady++;
      end
      n_cmp++; if (nrd !== 2) begin n_err++; $display("FAIL bp_reads got=%0d exp=2", nrd); end
      n_cmp++; if (unsteady !== 0) begin n_err++; $display("FAIL bp_steady changes=%0d exp=0", unsteady); end
      n_cmp++; if (rcount !== 5'd14) begin n_err++; $display("FAIL bp_rcount got=%0d exp=14", rcount); end
      n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_tvalid got=%0b exp=1", m_tvalid); end
      n_cmp++; if (ralmost_empty !== 1'b0) begin n_err++; $display("FAIL bp_ae got=%0b exp=0", ralmost_empty); end
      m_tready = 1'b1;
      for (int c = 0; c < 60 && beats < 16; c++) begin
         if (m_tvalid) begin
            if (m_tdata !== 32'(100 + beats)) begin
               bad++;
               $display("FAIL bp_data beat=%0d got=%0d exp=%0d", beats, m_tdata, 100 + beats);
            end
            beats++;
         end
         step();
      end
      n_cmp++; if (beats !== 16) begin n_err++; $display("FAIL bp_beats got=%0d exp=16", beats); end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_order bad=%0d exp=0", bad); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL bp_drain_tvalid got=%0b exp=0", m_tvalid); end
      n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL bp_drain_rempty got=%0b exp=1", rempty); end
      n_cmp++; if (rcount !== 5'd0) begin n_err++; $display("FAIL bp_drain_rcount got=%0d exp=0", rcount); end
   endtask

   task automatic test_wrap();
      int written = 0;
      int popped = 0;
      int bad = 0;
      bit seen31 = 0;
      bit wrapped = 0;
      do_reset();
      for (int c = 0; c < 600 && popped < 40; c++) begin
         m_tready = (c % 4) != 3;
         if (m_tvalid && m_tready) begin
            if (m_tdata !== 32'(200 + popped)) begin
               bad++;
               $display("FAIL wrap_data idx=%0d got=%0d exp=%0d", popped, m_tdata, 200 + popped);
            end
            popped++;
         end
         if (written < 40 && (written - popped) < 16 && (c % 5) != 4) begin
            mem[written % 16] = 32'(200 + written);
            written++;
            rq2_wptr = g(written);
         end
         if (rptr == g(31)) seen31 = 1'b1;
         if (seen31 && rptr == g(32)) wrapped = 1'b1;
         step();
      end
      step(); step();
      n_cmp++; if (popped !== 40) begin n_err++; $display("FAIL wrap_count got=%0d exp=40", popped); end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL wrap_order bad=%0d exp=0", bad); end
      n_cmp++; if (wrapped !== 1'b1) begin n_err++; $display("FAIL wrap_rptr_msb got=%0b exp=1", wrapped); end
      n_cmp++; if (rptr !== g(40)) begin n_err++; $display("FAIL wrap_final_rptr got=%0h exp=%0h", rptr, g(40)); end
      n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL wrap_rempty got=%0b exp=1", rempty); end
      n_cmp++; if (rcount !== 5'd0) begin n_err++; $display("FAIL wrap_rcount got=%0d exp=0", rcount); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL wrap_tvalid got=%0b exp=0", m_tvalid); end
   endtask

   task automatic test_mid_reset();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 4; i++) mem[i] = 32'(300 + i);
      rq2_wptr = g(4);
      m_tready = 1'b0;
      for (int c = 0; c < 6; c++) step();
      n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL mr_pre_tvalid got=%0b exp=1", m_tvalid); end
      n_cmp++; if (m_tdata !== 32'd300) begin n_err++; $display("FAIL mr_pre_tdata got=%0d exp=300", m_tdata); end
      rrst_n = 1'b0;
      rq2_wptr = '0;
      m_tready = 1'b1;
      step();
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL mr_tvalid got=%0b exp=0", m_tvalid); end
      n_cmp++; if (rptr !== 5'd0) begin n_err++; $display("FAIL mr_rptr got=%0h exp=0", rptr); end
      n_cmp++; if (rden !== 1'b0) begin n_err++; $display("FAIL mr_rden got=%0b exp=0", rden); end
      n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL mr_rempty got=%0b exp=1", rempty); end
      rrst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         if (m_tvalid) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL mr_after_pulses got=%0d exp=0", pulses); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rrst_n = 1'b0;
      rq2_wptr = '0;
      m_tready = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      @(negedge rclk);
      test_reset();
      test_first_word();
      test_streaming();
      test_almost_empty();
      test_backpressure();
      test_wrap();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
